hdmi_i2c_init_seq: RTL and testbench
====================================

Name: hdmi_i2c_init_seq

Overview:
Upstream sequencer for the HDMI transmitter configuration path. It walks a 24-bit register table {dev_addr[23:16], reg_addr[15:8], data[7:0]}, fetching one entry per step from a synchronous ROM. It hands each entry to the byte-level I2C write engine through a valid/ready request plus a done/nack response, retries NACKed writes, and reports completion or failure to the top level.

Parameters:
NUM_ENTRIES, 20, number of table entries executed (indices 0..NUM_ENTRIES-1).
ADDR_W, 6, width of the table index.
PWRUP_CYCLES, 1000, clocks to wait after start before the first write (transmitter power-up).
MAX_RETRIES, 3, NACK retries allowed per entry before declaring error.
RETRY_GAP, 64, idle clocks between a NACK and the reissue.
DELAY_DEV, 8'hFE, dev_addr value marking a delay entry instead of a write.

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse; begins or restarts the sequence
rom_addr  out  ADDR_W  table index; ROM data valid one clock later
rom_data  in  24  table entry
wr_valid  out  1  write request to the I2C engine
wr_ready  in  1  engine accepts the request
wr_dev  out  8  slave address byte
wr_reg  out  8  register address byte
wr_data  out  8  data byte
wr_done  in  1  single-cycle pulse when the transaction ends
wr_nack  in  1  qualifies wr_done: 1 = any byte NACKed
hpd  in  1  hot-plug detect (asynchronous; used only with the option)
busy  out  1  sequence in progress
done  out  1  all entries written; held until next start
error  out  1  retry budget exhausted; held until next start
err_index  out  ADDR_W  index of the failing entry
retry_cnt  out  2  retries used on the current entry

Behaviour:
- Reset (reset_n=0 at clock edge): state IDLE. rom_addr, wr_* buses, err_index and retry_cnt are 0. wr_valid, busy, done and error are 0.
- States: IDLE, PWRUP, FETCH, LATCH, ISSUE, WAIT_RESP, GAP, DELAY, DONE, ERROR.
- IDLE/DONE/ERROR + start: clear done, error and retry_cnt; set index=0 and busy=1; go to PWRUP.
- start in any other state: ignored, except in PWRUP, where it restarts the power-up count.
- PWRUP: count PWRUP_CYCLES clocks, then go to FETCH.
- FETCH: drive rom_addr=index for one clock, then go to LATCH.
- LATCH: capture rom_data.
  - dev == DELAY_DEV: go to DELAY, loading {reg,data}×16 clocks.
  - Otherwise: load the wr_* buses, assert wr_valid, go to ISSUE.
- ISSUE: hold wr_valid and the buses stable until wr_ready=1 on an edge. Deassert wr_valid the next cycle; go to WAIT_RESP.
- WAIT_RESP: on wr_done.
  - wr_nack=0: if index==NUM_ENTRIES-1, go to DONE; else index+1, retry_cnt=0, go to FETCH.
  - wr_nack=1 and retry_cnt<MAX_RETRIES: retry_cnt+1, go to GAP.
  - wr_nack=1 and retry_cnt==MAX_RETRIES: err_index=index, go to ERROR.
- GAP: wait RETRY_GAP clocks, then reassert wr_valid with the same buses; go to ISSUE. No ROM refetch.
- DELAY: count down to 0, then advance index exactly as for a successful write. A delay value of 0 completes after one clock.
- DONE: busy=0, done=1. ERROR: busy=0, error=1. Both hold until the next start.
- Timing:
  - Entry-to-request latency: 2 clocks (FETCH, LATCH).
  - A wr_done arriving in the same cycle as wr_ready is ignored; the engine never does this.
- Counters: index never wraps past NUM_ENTRIES-1. retry_cnt saturates at MAX_RETRIES.
- Reset mid-transaction: everything returns to reset values immediately. A pending engine response is ignored because the state is IDLE.

Optional Feature:
HPD_REINIT_EN:
- Defined: hpd passes through a 2-flop synchroniser, then must be stable high for 1024 clocks. The debounced rising edge acts as start when the block is in IDLE, DONE or ERROR. A debounced falling edge during busy aborts to IDLE, clears busy and drops wr_valid, but never while wr_valid=1 and wr_ready=1 in the same cycle.
- Undefined: hpd is unused and only start begins a sequence.

Test Plan:
- Normal run: NUM_ENTRIES=3, ROM {72_41_10, 72_98_03, 72_9A_E0}, engine acks all → three requests in order, busy high throughout, done=1 after the third wr_done, rom_addr ended at 2.
- Backpressure: wr_ready held 0 for 10 clocks on entry 1 → wr_valid and the buses are stable for all 10 clocks, exactly one request accepted.
- Single NACK: entry 0 NACKed once → RETRY_GAP idle clocks, identical reissue with no ROM fetch between, retry_cnt=1, sequence completes with done=1.
- Exhausted retries: entry 1 always NACKed → 4 attempts total, then error=1, err_index=1, done=0, busy=0.
- Delay entry: entry {FE,00,04} → no wr_valid for 64 clocks, then the next entry is fetched.
- Reset and restart: reset_n=0 during WAIT_RESP → all outputs are at reset values the next cycle. A start pulse in ISSUE is ignored; a start pulse after DONE reruns from index 0.

Source files
------------

// File: rtl/hdmi_i2c_init_seq.sv
// HDMI transmitter register-table sequencer: walks a ROM of {dev,reg,data} entries and
// drives a byte-level I2C write engine. Optional HPD-driven re-init under `HPD_REINIT_EN.
module hdmi_i2c_init_seq #(
  parameter int         NUM_ENTRIES  = 20,
  parameter int         ADDR_W       = 6,
  parameter int         PWRUP_CYCLES = 1000,
  parameter int         MAX_RETRIES  = 3,
  parameter int         RETRY_GAP    = 64,
  parameter logic [7:0] DELAY_DEV    = 8'hFE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [7:0]        wr_dev,
  output logic [7:0]        wr_reg,
  output logic [7:0]        wr_data,
  input  logic              wr_done,
  input  logic              wr_nack,
  input  logic              hpd,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_index,
  output logic [1:0]        retry_cnt
);

  // One shared down-counter covers power-up, retry gap and delay entries ({reg,data}*16).
  localparam int                CNT_W    = 20;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ENTRIES - 1);
  localparam logic [1:0]        MAX_R    = 2'(MAX_RETRIES);
  localparam logic [CNT_W-1:0]  PWR_LOAD = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(RETRY_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_LATCH, S_ISSUE,
    S_WAIT_RESP, S_GAP, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        retry_q, retry_d;
  logic              wr_valid_q, wr_valid_d;
  logic [7:0]        wr_dev_q, wr_dev_d;
  logic [7:0]        wr_reg_q, wr_reg_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] err_idx_q, err_idx_d;
  logic              advance;
  logic              start_evt;
  logic              abort;

`ifdef HPD_REINIT_EN
  logic       hpd_s1_q, hpd_s2_q;
  logic       hpd_db_q, hpd_db_d;
  logic [9:0] db_cnt_q, db_cnt_d;
  logic       abort_pend_q, abort_pend_d;
  logic       hpd_rise, hpd_fall, abort_req;

  // Debounced level flips only after the synchronised input disagrees for 1024 clocks.
  always_comb begin
    db_cnt_d = db_cnt_q;
    hpd_db_d = hpd_db_q;
    hpd_rise = 1'b0;
    hpd_fall = 1'b0;
    if (hpd_s2_q == hpd_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == 10'h3FF) begin
      db_cnt_d = '0;
      hpd_db_d = hpd_s2_q;
      hpd_rise = hpd_s2_q;
      hpd_fall = ~hpd_s2_q;
    end else begin
      db_cnt_d = db_cnt_q + 10'd1;
    end
    start_evt    = start | hpd_rise;
    // An abort is held off while a handshake completes, then taken the next cycle.
    abort_req    = (abort_pend_q | hpd_fall) & busy_q;
    abort        = abort_req & ~(wr_valid_q & wr_ready);
    abort_pend_d = abort_req & ~abort;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hpd_s1_q     <= 1'b0;
      hpd_s2_q     <= 1'b0;
      hpd_db_q     <= 1'b0;
      db_cnt_q     <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      hpd_s1_q     <= hpd;
      hpd_s2_q     <= hpd_s1_q;
      hpd_db_q     <= hpd_db_d;
      db_cnt_q     <= db_cnt_d;
      abort_pend_q <= abort_pend_d;
    end
  end
`else
  logic unused_hpd;
  assign unused_hpd = hpd;
  assign start_evt  = start;
  assign abort      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    wr_valid_d = wr_valid_q;
    wr_dev_d   = wr_dev_q;
    wr_reg_d   = wr_reg_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;
    advance    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_evt) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          retry_d = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = PWR_LOAD;
          state_d = S_PWRUP;
        end
      end
      S_PWRUP: begin
        if (start_evt)       cnt_d   = PWR_LOAD;
        else if (cnt_q == 0) state_d = S_FETCH;
        else                 cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (rom_data[23:16] == DELAY_DEV) begin
          cnt_d   = {rom_data[15:0], 4'b0000};
          state_d = S_DELAY;
        end else begin
          wr_dev_d   = rom_data[23:16];
          wr_reg_d   = rom_data[15:8];
          wr_data_d  = rom_data[7:0];
          wr_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_ready) begin
          wr_valid_d = 1'b0;
          state_d    = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (wr_done) begin
          if (!wr_nack) begin
            advance = 1'b1;
          end else if (retry_q < MAX_R) begin
            retry_d = retry_q + 2'd1;
            cnt_d   = GAP_LOAD;
            state_d = S_GAP;
          end else begin
            err_idx_d = idx_q;
            busy_d    = 1'b0;
            error_d   = 1'b1;
            state_d   = S_ERROR;
          end
        end
      end
      // Reissue reuses the latched buses; the ROM is not read again.
      S_GAP: begin
        if (cnt_q == 0) begin
          wr_valid_d = 1'b1;
          state_d    = S_ISSUE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DELAY: begin
        if (cnt_q == 0) advance = 1'b1;
        else            cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + ADDR_W'(1);
        retry_d = '0;
        state_d = S_FETCH;
      end
    end

    if (abort) begin
      busy_d     = 1'b0;
      wr_valid_d = 1'b0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      retry_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_dev_q   <= '0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      wr_valid_q <= wr_valid_d;
      wr_dev_q   <= wr_dev_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign rom_addr  = idx_q;
  assign wr_valid  = wr_valid_q;
  assign wr_dev    = wr_dev_q;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_idx_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_hdmi_i2c_init_seq.sv
// Directed bench for hdmi_i2c_init_seq: behavioural ROM and I2C engine, per-scenario tasks.
`timescale 1ns/1ps
module tb_hdmi_i2c_init_seq;
  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          hpd = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_done = 1'b0;
  logic          wr_nack = 1'b0;
  logic [23:0]   rom_data;
  logic [AW-1:0] rom_addr, err_index;
  logic          wr_valid, busy, done, error;
  logic [7:0]    wr_dev, wr_reg, wr_data;
  logic [1:0]    retry_cnt;

  logic [23:0] rom [0:63];
  int checks = 0;
  int errors = 0;

  // engine controls
  int         stall_left = 0;
  int         nack_left = 0;
  int         resp_t = 0;
  logic [7:0] stall_reg = 8'h00;
  logic [7:0] nack_reg = 8'h00;
  logic [7:0] acc_reg = 8'h00;

  // monitor state
  logic [23:0] acc_log [$];
  logic [23:0] stall_exp = 24'h0;
  int          stall_seen = 0;
  int          stall_bad = 0;
  int          gap_n = 0;
  int          gap_last = -1;
  int          nack_gap = -1;
  bit          gap_meas = 1'b0;
  bit          gap_nack = 1'b0;
  logic [1:0]  nack_retry = 2'd0;

  hdmi_i2c_init_seq #(
    .NUM_ENTRIES(3), .ADDR_W(AW), .PWRUP_CYCLES(20),
    .MAX_RETRIES(3), .RETRY_GAP(64), .DELAY_DEV(8'hFE)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data),
    .wr_done(wr_done), .wr_nack(wr_nack), .hpd(hpd),
    .busy(busy), .done(done), .error(error),
    .err_index(err_index), .retry_cnt(retry_cnt)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom[rom_addr];

  // I2C engine: accepts when not stalled, answers 3 clocks after acceptance.
  initial begin
    forever begin
      @(posedge clock); #1;
      wr_done = 1'b0;
      wr_nack = 1'b0;
      if (wr_ready) begin
        wr_ready = 1'b0;
        resp_t   = 3;
      end else if (resp_t > 0) begin
        resp_t--;
        if (resp_t == 0) begin
          wr_done = 1'b1;
          if (acc_reg == nack_reg && nack_left > 0) begin
            wr_nack = 1'b1;
            if (nack_left < 99) nack_left--;
          end
        end
      end else if (wr_valid) begin
        if (stall_left > 0 && wr_reg == stall_reg) stall_left--;
        else wr_ready = 1'b1;
      end
    end
  end

  // Monitor: accepted requests, stalled cycles and idle gaps after each response.
  initial begin
    forever begin
      @(negedge clock);
      if (wr_valid && wr_ready) begin
        acc_log.push_back({wr_dev, wr_reg, wr_data});
        acc_reg = wr_reg;
      end
      if (wr_valid && !wr_ready) begin
        stall_seen++;
        if ({wr_dev, wr_reg, wr_data} !== stall_exp) stall_bad++;
      end
      if (gap_meas && wr_valid) begin
        gap_last = gap_n;
        if (gap_nack) begin
          nack_gap   = gap_n;
          nack_retry = retry_cnt;
        end
        gap_meas = 1'b0;
      end else if (gap_meas) begin
        gap_n++;
      end
      if (wr_done) begin
        gap_meas = 1'b1;
        gap_nack = wr_nack;
        gap_n    = 0;
      end
    end
  end

  function automatic logic [23:0] get_acc(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 24'hxxxxxx;
  endfunction

  function automatic int count_reg(input logic [7:0] r);
    int n = 0;
    foreach (acc_log[i]) if (acc_log[i][15:8] == r) n++;
    return n;
  endfunction

  task automatic load_rom(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    rom[0] = a; rom[1] = b; rom[2] = c;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    stall_left = 0;
    nack_left  = 0;
    repeat (6) @(posedge clock);
    #1 reset_n = 1'b1;
    acc_log.delete();
    stall_seen = 0; stall_bad = 0;
    gap_meas = 1'b0; gap_last = -1; nack_gap = -1;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic wait_end(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clock);
      if (done || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if ({wr_valid, busy, done, error} !== 4'b0)
      begin errors++; $display("FAIL reset_flags got %b want 0000", {wr_valid, busy, done, error}); end
    checks++; if ({wr_dev, wr_reg, wr_data} !== 24'h0)
      begin errors++; $display("FAIL reset_bus got %h want 000000", {wr_dev, wr_reg, wr_data}); end
    checks++; if (rom_addr !== '0)
      begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    checks++; if ({err_index, retry_cnt} !== '0)
      begin errors++; $display("FAIL reset_err_retry got %0d/%0d want 0/0", err_index, retry_cnt); end
  endtask

  task automatic test_normal();
    bit ok;
    int busy_low = 0;
    load_rom(24'h724110, 24'h729803, 24'h729AE0);
    do_reset();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (done) begin ok = 1'b1; break; end
      if (!busy) busy_low++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL normal_timeout got done=%b want 1", done); end
    checks++; if (acc_log.size() !== 3)
      begin errors++; $display("FAIL normal_count got %0d want 3", acc_log.size()); end
    checks++; if (get_acc(0) !== 24'h724110)
      begin errors++; $display("FAIL normal_req0 got %h want 724110", get_acc(0)); end
    checks++; if (get_acc(1) !== 24'h729803)
      begin errors++; $display("FAIL normal_req1 got %h want 729803", get_acc(1)); end
    checks++; if (get_acc(2) !== 24'h729AE0)
      begin errors++; $display("FAIL normal_req2 got %h want 729ae0", get_acc(2)); end
    checks++; if (busy_low !== 0)
      begin errors++; $display("FAIL normal_busy got %0d low cycles want 0", busy_low); end
    checks++; if (rom_addr !== 6'd2)
      begin errors++; $display("FAIL normal_rom_addr got %0d want 2", rom_addr); end
    checks++; if ({busy, error} !== 2'b00)
      begin errors++; $display("FAIL normal_end_flags got %b want 00", {busy, error}); end
    checks++; if (gap_last !== 2)
      begin errors++; $display("FAIL normal_latency got %0d want 2", gap_last); end
  endtask

  task automatic test_backpressure();
    bit ok;
    load_rom(24'h724110, 24'h729803, 24'h729AE0);
    do_reset();
    stall_reg = 8'h98; stall_left = 10; stall_exp = 24'h729803;
    pulse_start();
    wait_end(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got done=%b want 1", done); end
    checks++; if (stall_seen !== 10)
      begin errors++; $display("FAIL bp_stall_cycles got %0d want 10", stall_seen); end
    checks++; if (stall_bad !== 0)
      begin errors++; $display("FAIL bp_bus_stable got %0d changes want 0", stall_bad); end
    checks++; if (count_reg(8'h98) !== 1)
      begin errors++; $display("FAIL bp_accepts got %0d want 1", count_reg(8'h98)); end
    checks++; if (done !== 1'b1)
      begin errors++; $display("FAIL bp_done got %b want 1", done); end
  endtask

  task automatic test_single_nack();
    bit ok;
    load_rom(24'h724110, 24'h729803, 24'h729AE0);
    do_reset();
    nack_reg = 8'h41; nack_left = 1;
    pulse_start();
    wait_end(800, ok);
    checks++; if (!ok || done !== 1'b1)
      begin errors++; $display("FAIL nack1_done got %b want 1", done); end
    checks++; if (acc_log.size() !== 4)
      begin errors++; $display("FAIL nack1_count got %0d want 4", acc_log.size()); end
    checks++; if (get_acc(1) !== 24'h724110)
      begin errors++; $display("FAIL nack1_reissue got %h want 724110", get_acc(1)); end
    checks++; if (nack_gap !== 64)
      begin errors++; $display("FAIL nack1_gap got %0d want 64", nack_gap); end
    checks++; if (nack_retry !== 2'd1)
      begin errors++; $display("FAIL nack1_retry_cnt got %0d want 1", nack_retry); end
    checks++; if (get_acc(3) !== 24'h729AE0)
      begin errors++; $display("FAIL nack1_last got %h want 729ae0", get_acc(3)); end
  endtask

  task automatic test_retry_exhaust();
    bit ok;
    load_rom(24'h724110, 24'h729803, 24'h729AE0);
    do_reset();
    nack_reg = 8'h98; nack_left = 99;
    pulse_start();
    wait_end(1500, ok);
    checks++; if (!ok || error !== 1'b1)
      begin errors++; $display("FAIL exh_error got %b want 1", error); end
    checks++; if (count_reg(8'h98) !== 4)
      begin errors++; $display("FAIL exh_attempts got %0d want 4", count_reg(8'h98)); end
    checks++; if (err_index !== 6'd1)
      begin errors++; $display("FAIL exh_err_index got %0d want 1", err_index); end
    checks++; if ({done, busy} !== 2'b00)
      begin errors++; $display("FAIL exh_flags got %b want 00", {done, busy}); end
    checks++; if (retry_cnt !== 2'd3)
      begin errors++; $display("FAIL exh_retry_cnt got %0d want 3", retry_cnt); end
    checks++; if (acc_log.size() !== 5)
      begin errors++; $display("FAIL exh_total got %0d want 5", acc_log.size()); end
  endtask

  task automatic test_delay();
    bit ok;
    load_rom(24'h724110, 24'hFE0004, 24'h729AE0);
    do_reset();
    pulse_start();
    wait_end(800, ok);
    checks++; if (!ok || done !== 1'b1)
      begin errors++; $display("FAIL delay_done got %b want 1", done); end
    checks++; if (acc_log.size() !== 2)
      begin errors++; $display("FAIL delay_count got %0d want 2", acc_log.size()); end
    checks++; if (get_acc(1) !== 24'h729AE0)
      begin errors++; $display("FAIL delay_next got %h want 729ae0", get_acc(1)); end
    // 2 (fetch+latch) + 65 (delay 64..0) + 2 (fetch+latch)
    checks++; if (gap_last !== 69)
      begin errors++; $display("FAIL delay_gap got %0d want 69", gap_last); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad = 0;
    load_rom(24'h724110, 24'h729803, 24'h729AE0);
    do_reset();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (acc_log.size() == 1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rmid_accept got %0d want 1", acc_log.size()); end
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    checks++; if ({wr_valid, busy, done, error, rom_addr, retry_cnt} !== '0)
      begin errors++; $display("FAIL rmid_outputs got %b want 0", {wr_valid, busy, done, error, rom_addr, retry_cnt}); end
    checks++; if ({wr_dev, wr_reg, wr_data} !== 24'h0)
      begin errors++; $display("FAIL rmid_bus got %h want 000000", {wr_dev, wr_reg, wr_data}); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (wr_valid || busy || done || error || rom_addr != 0) bad++;
    end
    checks++; if (bad !== 0)
      begin errors++; $display("FAIL rmid_idle got %0d active cycles want 0", bad); end
  endtask

  task automatic test_restart();
    bit ok;
    load_rom(24'h724110, 24'h729803, 24'h729AE0);
    do_reset();
    stall_reg = 8'h98; stall_left = 10; stall_exp = 24'h729803;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (stall_seen >= 3) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_stall got %0d want 3", stall_seen); end
    pulse_start();
    @(negedge clock);
    checks++; if ({busy, rom_addr} !== {1'b1, 6'd1})
      begin errors++; $display("FAIL rst_issue_ignore got busy=%b addr=%0d want 1/1", busy, rom_addr); end
    wait_end(600, ok);
    checks++; if (!ok || acc_log.size() !== 3)
      begin errors++; $display("FAIL rst_no_restart got %0d reqs want 3", acc_log.size()); end
    acc_log.delete();
    pulse_start();
    @(negedge clock);
    checks++; if ({done, busy, rom_addr} !== {1'b0, 1'b1, 6'd0})
      begin errors++; $display("FAIL rst_rerun_start got done=%b busy=%b addr=%0d want 0/1/0", done, busy, rom_addr); end
    wait_end(600, ok);
    checks++; if (!ok || done !== 1'b1)
      begin errors++; $display("FAIL rst_rerun_done got %b want 1", done); end
    checks++; if (get_acc(0) !== 24'h724110 || acc_log.size() !== 3)
      begin errors++; $display("FAIL rst_rerun_order got %h n=%0d want 724110 n=3", get_acc(0), acc_log.size()); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 24'h0;
    test_reset();
    test_normal();
    test_backpressure();
    test_single_nack();
    test_retry_exhaust();
    test_delay();
    test_reset_mid();
    test_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
